// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_pkg
//  Description : Shared types and constants for the RAM responder: FSM state
//                encoding, access opcode, out-of-range read pattern and
//                default geometry/latency.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      READY = 2'd2
   } state_t;

   // Latched access direction
   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // Data returned for a read whose address lies beyond the array
   localparam logic [31:0] BAD_DATA = 32'hBAD0_BAD0;

   // Default configuration
   localparam int DEF_LAT    = 2;
   localparam int DEF_DEPTH  = 1024;
   localparam int DEF_ADDR_W = 10;

   // Latency counter width; covers the full 1..15 latency range
   localparam int CNT_W = 4;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_if
//  Description : Single-port RAM bus between the memory controller (master)
//                and the RAM responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_if;

   logic        Ren;       // read request
   logic        Wen;       // write request
   logic [31:0] ramaddr;   // byte address
   logic [31:0] ramstore;  // write data
   logic [31:0] ramload;   // read data, valid in read completion cycle
   logic        busy_o;    // request in progress
   logic        oob_o;     // sticky out-of-range flag

   modport master (
      output Ren, Wen, ramaddr, ramstore,
      input  ramload, busy_o, oob_o
   );

   modport slave (
      input  Ren, Wen, ramaddr, ramstore,
      output ramload, busy_o, oob_o
   );

endinterface : ram_if
`default_nettype wire

// File: rtl/ram_array.sv
`default_nettype none
// ============================================================================
//  Module      : ram_array
//  Description : DEPTH x 32 storage, combinational read port and synchronous
//                write port sharing one word address. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_array #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  wire logic              clk_i,
   input  wire logic              we_i,
   input  wire logic [ADDR_W-1:0] addr_i,
   input  wire logic [31:0]       wdata_i,
   output logic      [31:0]       rdata_o
);

   logic [31:0] mem_q [DEPTH];

   assign rdata_o = mem_q[addr_i];

   // Commit a word on the closing edge of an enabled cycle
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

endmodule : ram_array
`default_nettype wire

// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ram_responder
//  Description : Responder end of the controller's single-port RAM bus.
//                busy_o is held for LAT cycles per request; the access
//                completes in the following cycle (read data on ramload,
//                write committed at its closing edge).
//                Optional build macro RAM_BOUNDS_EN: addresses beyond DEPTH
//                words read BAD_DATA, drop writes and set sticky oob_o.
//                Without it, the upper address bits are ignored (wrap).
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_responder
   import ram_pkg::*;
#(
   parameter int LAT    = DEF_LAT,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input wire logic CLK,
   input wire logic nRST,
   ram_if.slave     bus
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(LAT - 1);

   // Request decode
   logic              w_req_valid;
   op_t               w_req_op;
   logic [ADDR_W-1:0] w_req_idx;
   logic              w_req_oob;
   logic              w_unused_addr;

   // Latched request and FSM state
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [ADDR_W-1:0] idx_q,   idx_d;
   op_t               op_q,    op_d;
   logic              hi_q,    hi_d;    // latched request is out of range
   logic              oob_q,   oob_d;

   logic              w_match;
   logic              w_complete;
   logic              w_start;
   logic              w_we;
   logic [31:0]       w_rdata;

   // Both-asserted and both-deasserted are the controller's idle encodings
   assign w_req_valid = bus.Ren ^ bus.Wen;
   assign w_req_op    = bus.Ren ? OP_RD : OP_WR;
   assign w_req_idx   = bus.ramaddr[ADDR_W+1:2];

`ifdef RAM_BOUNDS_EN
   assign w_req_oob     = |bus.ramaddr[31:ADDR_W+2];
   assign w_unused_addr = ^bus.ramaddr[1:0];
`else
   assign w_req_oob     = 1'b0;
   assign w_unused_addr = ^{bus.ramaddr[31:ADDR_W+2], bus.ramaddr[1:0]};
`endif

   // The held request is the one that was latched
   assign w_match    = w_req_valid && (w_req_op == op_q) &&
                       (w_req_idx == idx_q) && (w_req_oob == hi_q);
   assign w_complete = (state_q == READY) && w_match;

   // New request from idle, or a different request replacing the pending one
   assign w_start    = w_req_valid && ((state_q == IDLE) || !w_match);

   assign w_we       = w_complete && (op_q == OP_WR) && !hi_q;

   assign bus.busy_o  = w_req_valid && !w_complete;
   assign bus.ramload = (w_complete && (op_q == OP_RD)) ?
                        (hi_q ? BAD_DATA : w_rdata) : 32'h0;
   // Visible in the completion cycle itself, then held by oob_q
   assign bus.oob_o   = oob_q || (w_complete && hi_q);

   ram_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk_i   (CLK),
      .we_i    (w_we),
      .addr_i  (idx_q),
      .wdata_i (bus.ramstore),
      .rdata_o (w_rdata)
   );

   // State and latched-request registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         op_q    <= OP_RD;
         hi_q    <= 1'b0;
         oob_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         oob_q   <= oob_d;
      end
   end

   // Next-state: latch/relatch, count down latency, complete or abort
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      op_d    = op_q;
      hi_d    = hi_q;
      oob_d   = oob_q || (w_complete && hi_q);

      if (!w_req_valid) begin
         state_d = IDLE;
      end else if (w_start) begin
         idx_d   = w_req_idx;
         op_d    = w_req_op;
         hi_d    = w_req_oob;
         cnt_d   = RELOAD;
         state_d = (LAT == 1) ? READY : COUNT;
      end else begin
         case (state_q)
            COUNT: begin
               if (cnt_q == CNT_W'(1)) begin
                  state_d = READY;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            READY:   state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

endmodule : ram_responder
`default_nettype wire
